// File: rtl/cl_pkg.sv
// Shared types, tap geometry and the ramp pattern for the Camera Link frame generator.
package cl_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HBLANK, HOLD, VBLANK} cl_state_e;

  localparam int CL_TAPS  = 10;
  localparam int CL_TAP_W = 8;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int cl_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int cl_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [CL_TAP_W-1:0] pixel(input logic [7:0] frame, input logic [7:0] line,
                                                input logic [7:0] col, input int k);
    logic [7:0] k8;
    k8 = 8'(k);
    return frame + line + col * 8'd10 + k8;
  endfunction
endpackage

// File: rtl/cl_pattern.sv
// Registered 10-tap ramp generator; inputs are the counters for the cycle being loaded.
module cl_pattern
  import cl_pkg::*;
#(
  parameter int COL_W  = 1,
  parameter int LINE_W = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              active_i,
  input  logic [COL_W-1:0]                  col_i,
  input  logic [LINE_W-1:0]                 line_i,
  input  logic [7:0]                        frame_i,
  output logic [CL_TAPS-1:0][CL_TAP_W-1:0]  taps_o
);
  logic [7:0] col8, line8;
  assign col8  = 8'(col_i);
  assign line8 = 8'(line_i);

  for (genvar k = 0; k < CL_TAPS; k++) begin : g_tap
    logic [CL_TAP_W-1:0] tap_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tap_q <= '0;
      else       tap_q <= active_i ? pixel(frame_i, line8, col8, k) : '0;
    end
    assign taps_o[k] = tap_q;
  end
endmodule

// File: rtl/cl_gen.sv
// Camera Link 10-tap frame generator: FSM, line/column/frame counters, registered outputs.
module cl_gen
  import cl_pkg::*;
#(
  parameter int H_ACTIVE   = 128,
  parameter int H_BLANK    = 16,
  parameter int V_ACTIVE   = 1024,
  parameter int V_BLANK    = 64,
  parameter int FVAL_SETUP = 4,
  parameter int FVAL_HOLD  = 4
) (
  input  logic       cl_x_pclk,
  input  logic       reset,
  input  logic       enable,
  output logic       cl_fval,
  output logic       cl_x_lval,
  output logic       cl_y_lval,
  output logic       cl_z_lval,
  output logic [7:0] cl_port_a,
  output logic [7:0] cl_port_b,
  output logic [7:0] cl_port_c,
  output logic [7:0] cl_port_d,
  output logic [7:0] cl_port_e,
  output logic [7:0] cl_port_f,
  output logic [7:0] cl_port_g,
  output logic [7:0] cl_port_h,
  output logic [7:0] cl_port_i,
  output logic [7:0] cl_port_j,
  output logic       frame_done,
  output logic [7:0] led8
);
  localparam int COL_W  = cl_w(H_ACTIVE);
  localparam int LINE_W = cl_w(V_ACTIVE);
  localparam int TMR_W  = cl_w(cl_max(cl_max(FVAL_SETUP, H_BLANK), cl_max(FVAL_HOLD, V_BLANK)));

  cl_state_e         state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [7:0]        frame_q, frame_d;
  logic              fval_q, lval_q, done_q, done_d;
  logic [CL_TAPS-1:0][CL_TAP_W-1:0] taps;

  // tmr_q counts clocks inside the fixed-length non-active states.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    line_d  = line_q;
    frame_d = frame_q;
    done_d  = 1'b0;
    tmr_d   = tmr_q + TMR_W'(1);
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (enable) state_d = SETUP;
      end
      SETUP:
        if (tmr_q == TMR_W'(FVAL_SETUP - 1)) begin
          state_d = ACTIVE;
          tmr_d   = '0;
        end
      ACTIVE: begin
        tmr_d = '0;
        col_d = col_q + COL_W'(1);
        if (col_q == COL_W'(H_ACTIVE - 1)) begin
          col_d = '0;
          if (line_q == LINE_W'(V_ACTIVE - 1)) begin
            state_d = HOLD;
            line_d  = '0;
          end else begin
            state_d = HBLANK;
            line_d  = line_q + LINE_W'(1);
          end
        end
      end
      HBLANK:
        if (tmr_q == TMR_W'(H_BLANK - 1)) begin
          state_d = ACTIVE;
          tmr_d   = '0;
        end
      HOLD:
        if (tmr_q == TMR_W'(FVAL_HOLD - 1)) begin
          state_d = VBLANK;
          tmr_d   = '0;
          frame_d = frame_q + 8'd1;
          done_d  = 1'b1;
        end
      VBLANK:
        if (tmr_q == TMR_W'(V_BLANK - 1)) begin
          state_d = enable ? SETUP : IDLE;
          tmr_d   = '0;
        end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Outputs are loaded from the next state so they line up with the registered state.
  always_ff @(posedge cl_x_pclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      line_q  <= '0;
      tmr_q   <= '0;
      frame_q <= '0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      line_q  <= line_d;
      tmr_q   <= tmr_d;
      frame_q <= frame_d;
      fval_q  <= (state_d != IDLE) && (state_d != VBLANK);
      lval_q  <= (state_d == ACTIVE);
      done_q  <= done_d;
    end
  end

  cl_pattern #(.COL_W(COL_W), .LINE_W(LINE_W)) u_pat (
    .clk_i    (cl_x_pclk),
    .rst_i    (reset),
    .active_i (state_d == ACTIVE),
    .col_i    (col_d),
    .line_i   (line_d),
    .frame_i  (frame_d),
    .taps_o   (taps)
  );

  assign cl_fval    = fval_q;
  assign cl_x_lval  = lval_q;
  assign cl_y_lval  = lval_q;
  assign cl_z_lval  = lval_q;
  assign frame_done = done_q;
  assign led8       = frame_q;
  assign cl_port_a  = taps[0];
  assign cl_port_b  = taps[1];
  assign cl_port_c  = taps[2];
  assign cl_port_d  = taps[3];
  assign cl_port_e  = taps[4];
  assign cl_port_f  = taps[5];
  assign cl_port_g  = taps[6];
  assign cl_port_h  = taps[7];
  assign cl_port_i  = taps[8];
  assign cl_port_j  = taps[9];
endmodule
